// File: rtl/mem_interface.sv
// Memory-side sequencer: one fetch/load/store per request, stalls the core until ack, timeout or misalign.
// Latency: 2 cycles minimum (accept, BUSY+ack, RESP); +1 per ack wait cycle; misaligned reports at cycle 1.
module mem_interface #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_fetch,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              stall,
  output logic              done,
  output logic              err,
  output logic [31:0]       ir,
  output logic [31:0]       mdr,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  localparam logic [7:0]  TO_CNT = 8'(TIMEOUT);
  localparam logic [31:0] NOP    = 32'h0000_0013;

  state_t            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              err_q, err_d;
  logic [31:0]       ir_q, ir_d;
  logic [31:0]       mdr_q, mdr_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [3:0]        mem_wstrb_q, mem_wstrb_d;
  logic              fetch_q, fetch_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [1:0]        off_q, off_d;

  logic [1:0]        eff_size;
  logic              misaligned;
  logic              is_store;
  logic [3:0]        strb;
  logic [31:0]       wdata_rep;
  logic [7:0]        byte_lane;
  logic [15:0]       half_lane;
  logic [31:0]       load_ext;
  logic [31:0]       rdata_shift;

  // Fetches are always word-sized; size 11 behaves as a word.
  assign eff_size   = req_fetch ? 2'b10 : (req_size == 2'b11 ? 2'b10 : req_size);
  assign misaligned = eff_size[1] ? (req_addr[1:0] != 2'b00)
                                  : (eff_size[0] & req_addr[0]);
  assign is_store   = req_we & ~req_fetch;

  always_comb begin
    strb      = 4'b1111;
    wdata_rep = req_wdata;
    if (eff_size == 2'b00) begin
      strb      = 4'b0001 << req_addr[1:0];
      wdata_rep = {4{req_wdata[7:0]}};
    end else if (eff_size == 2'b01) begin
      strb      = 4'b0011 << {req_addr[1], 1'b0};
      wdata_rep = {2{req_wdata[15:0]}};
    end
  end

  assign rdata_shift = mem_rdata >> {off_q, 3'b000};
  assign byte_lane   = rdata_shift[7:0];
  assign half_lane   = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

  always_comb begin
    load_ext = mem_rdata;
    if (size_q == 2'b00) begin
      load_ext = {{24{byte_lane[7] & ~uns_q}}, byte_lane};
    end else if (size_q == 2'b01) begin
      load_ext = {{16{half_lane[15] & ~uns_q}}, half_lane};
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    ir_d        = ir_q;
    mdr_d       = mdr_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    fetch_d     = fetch_q;
    size_d      = size_q;
    uns_d       = uns_q;
    off_d       = off_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          fetch_d = req_fetch;
          size_d  = eff_size;
          uns_d   = req_unsigned;
          off_d   = req_addr[1:0];
          cnt_d   = 8'd0;
          if (misaligned) begin
            state_d = RESP;
            err_d   = 1'b1;
          end else begin
            state_d     = BUSY;
            err_d       = 1'b0;
            mem_req_d   = 1'b1;
            mem_we_d    = is_store;
            mem_addr_d  = {req_addr[ADDR_W-1:2], 2'b00};
            mem_wdata_d = wdata_rep;
            mem_wstrb_d = is_store ? strb : 4'b0000;
          end
        end
      end
      BUSY: begin
        // An ack on the edge the count expires takes priority over the timeout.
        if (mem_ack) begin
          state_d     = RESP;
          err_d       = 1'b0;
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          mem_wstrb_d = 4'b0000;
          if (!mem_we_q) begin
            if (fetch_q) ir_d  = mem_rdata;
            else         mdr_d = load_ext;
          end
        end else if (cnt_q + 8'd1 == TO_CNT) begin
          state_d     = RESP;
          err_d       = 1'b1;
          cnt_d       = cnt_q + 8'd1;
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          mem_wstrb_d = 4'b0000;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= 8'd0;
      err_q       <= 1'b0;
      ir_q        <= NOP;
      mdr_q       <= 32'd0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'd0;
      mem_wstrb_q <= 4'b0000;
      fetch_q     <= 1'b0;
      size_q      <= 2'b00;
      uns_q       <= 1'b0;
      off_q       <= 2'b00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      ir_q        <= ir_d;
      mdr_q       <= mdr_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
      fetch_q     <= fetch_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      off_q       <= off_d;
    end
  end

  assign stall     = (state_q == BUSY) | ((state_q == IDLE) & req_valid);
  assign done      = (state_q == RESP);
  assign err       = err_q & done;
  assign ir        = ir_q;
  assign mdr       = mdr_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wstrb = mem_wstrb_q;

endmodule

// File: doc/mem_interface.md
# mem_interface

Memory-side sequencer between the multicycle RISC-V controller/datapath and a single shared instruction/data memory with variable-latency ready/ack handshake. It accepts one access request per controller state (fetch, load, or store) and stalls the controller until the access completes. It generates byte strobes for stores, extracts and extends load data, and latches results into the instruction register (IR) and the memory data register (MDR). Misaligned accesses and timeouts are reported as an error instead of hanging the core.

## Interface
- ADDR_W, 32, byte-address width.
- TIMEOUT, 15, maximum BUSY cycles to wait for `mem_ack` (1..255).

- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-low (0 = reset), sampled on rising edge of `clk`.
- req_valid  in  1  request present; held by controller until `done`.
- req_fetch  in  1  1 = instruction fetch (driven with IRWrite); forces word size and targets IR.
- req_we  in  1  1 = store (MemWrite); ignored when `req_fetch`=1.
- req_size  in  2  00 byte, 01 half, 10 word; 11 treated as word.
- req_unsigned  in  1  1 = zero-extend loads (lbu/lhu).
- req_addr  in  ADDR_W  byte address (AdrSrc-selected PC or ALUOut).
- req_wdata  in  32  store data, right-aligned.
- stall  out  1  controller must not advance its FSM while high.
- done  out  1  one-cycle completion pulse.
- err  out  1  valid with `done`; 1 = misaligned or timeout.
- ir  out  32  instruction register.
- mdr  out  32  extended load data.
- mem_req  out  1  registered memory request.
- mem_we  out  1  registered write enable.
- mem_addr  out  ADDR_W  word-aligned address (low 2 bits = 0).
- mem_wdata  out  32  lane-replicated store data.
- mem_wstrb  out  4  byte strobes (0000 on reads).
- mem_rdata  in  32  read data, valid with `mem_ack`.
- mem_ack  in  1  completion from memory.

## Operation
- FSM states: IDLE, BUSY, RESP.
- IDLE: when `req_valid`=1, sample all req_* fields.
  - If aligned, go to BUSY with `mem_req`=1.
  - If misaligned (half with addr[0]=1; word or fetch with addr[1:0]≠0), go to RESP with err latched. No memory access occurs.
- BUSY: hold `mem_req`, `mem_we`, `mem_addr`, `mem_wdata`, `mem_wstrb` stable.
  - On `mem_ack`=1: capture the result and go to RESP, err=0.
  - If no ack occurs and the wait counter reaches TIMEOUT: go to RESP with err=1, and leave IR/MDR unchanged.
- RESP: `done`=1 for exactly one cycle, then unconditionally return to IDLE. `req_valid` is ignored in RESP.
- Strobes and write data:
  - Byte: strobe = 0001 << addr[1:0]; wdata = byte replicated ×4.
  - Half: strobe = 0011 << (2·addr[1]); wdata = half replicated ×2.
  - Word: strobe = 1111.
- Load extract: select the lane by addr[1:0] (byte) or addr[1] (half), then sign-extend, or zero-extend if `req_unsigned`=1. Word loads pass through unchanged.
- IR loads `mem_rdata` only on a successful fetch. MDR loads only on a successful data read. Stores and errors modify neither register.
- `mem_ack` while `mem_req`=0 is ignored.

## Timing
- Reset (reset=0 at an edge): state=IDLE, stall=0, done=0, err=0, ir=0x00000013 (NOP), mdr=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_wstrb=0, wait counter=0.
- Reset during BUSY: `mem_req` drops on that edge, and a late ack is ignored.
- `stall` is combinational:
  - 1 in IDLE when `req_valid`=1.
  - 1 in BUSY.
  - 0 in RESP.
- Minimum latency, aligned access:
  - cycle 0: IDLE accepts the request.
  - cycle 1: BUSY, `mem_req`=1, `mem_ack`=1.
  - cycle 2: RESP, `done`=1, IR/MDR already updated.
- Each additional ack wait cycle adds one cycle of latency.
- Misaligned access: request accepted at cycle 0; `done`=`err`=1 at cycle 1.
- Timeout: the counter increments each BUSY cycle without ack. RESP with err follows after TIMEOUT BUSY cycles. An ack arriving on the same edge the count reaches TIMEOUT wins: the access succeeds.
- Back-to-back requests: a new request is accepted at the earliest in the cycle after RESP.

## Test plan
- Fetch at addr 0x00000008, ack on the first BUSY cycle, rdata 0x00500093 -> done at cycle 2, err=0, ir=0x00500093, mdr unchanged, stall high for cycles 0–1.
- lb at 0x00000103 (unsigned=0), rdata 0x80FF1234, ack after 3 wait cycles -> mdr=0xFFFFFF80, done at cycle 5; repeat with lbu -> mdr=0x00000080.
- sh at 0x00000102, wdata 0x0000ABCD -> mem_we=1, mem_addr=0x00000100, mem_wstrb=1100, mem_wdata=0xABCDABCD; mdr and ir unchanged.
- lw at 0x00000006 -> done=err=1 at cycle 1, mem_req never asserted, mdr unchanged.
- TIMEOUT=4, lw at 0x10, ack never arrives -> err=1 with done after 4 BUSY cycles; a later ack with mem_req=0 has no effect.
- reset=0 asserted during BUSY -> next edge gives mem_req=0, state IDLE, ir=0x00000013; an ack in the following cycle produces no done.
